// File: rtl/mbt_min_extract_if.sv
// Pop-minimum request/result bundle between the dequeue client and the min-extract engine.
// The client drives ext_req; the engine returns the tag along with its status flags.
interface mbt_min_extract_if #(
    parameter int N = 4
) ();
    logic           ext_req;
    logic           ext_ready;
    logic           tag_valid;
    logic [2*N-1:0] tag_out;
    logic           tag_empty;
    logic           err_incons;

    modport master (
        output ext_req,
        input  ext_ready, tag_valid, tag_out, tag_empty, err_incons
    );

    modport slave (
        input  ext_req,
        output ext_ready, tag_valid, tag_out, tag_empty, err_incons
    );
endinterface

// File: rtl/mbt_min_extract.sv
// Dequeue side of the two-level tag-sort tree. Finds the smallest set tag {node,bit} and removes it.
// The layer-1 bit is cleared only when the node drains and no concurrent insert is hitting that node.
module mbt_min_extract #(
    parameter int W = 16,
    parameter int N = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    mbt_min_extract_if.slave     ext,
    input  logic [W-1:0]         i_root_bitmap,
    output logic                 o_root_clr_valid,
    output logic [N-1:0]         o_root_clr_idx,
    output logic                 o_l2_rd_en,
    output logic [N-1:0]         o_l2_rd_addr,
    input  logic [W-1:0]         i_l2_rd_data,
    output logic                 o_l2_clr_valid,
    output logic [N-1:0]         o_l2_clr_addr,
    output logic [W-1:0]         o_l2_clr_mask,
    input  logic                 i_ins_valid,
    input  logic [N-1:0]         i_ins_node_addr
);

    // state  | meaning
    // IDLE   | ready for a pop request, root bitmap sampled here
    // READ   | layer-2 read of node idx1 issued
    // SCAN   | node word returned, pick lowest bit
    // CLEAR  | AND-NOT clear of the bit, optional layer-1 clear
    // DONE   | result pulse
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        READ  = 3'd1,
        SCAN  = 3'd2,
        CLEAR = 3'd3,
        DONE  = 3'd4
    } state_t;

    state_t         r_state;
    state_t         w_state_nxt;
    logic [N-1:0]   r_idx1;
    logic [N-1:0]   r_idx2;
    logic           r_empty;
    logic           r_err;
    logic           r_root_clr;
    logic           r_hit;

    logic           w_ins_hit;
    logic [N-1:0]   w_scan_idx;
    logic [W-1:0]   w_scan_onehot;
    logic           w_data_zero;
    logic           w_node_last;
    logic [W-1:0]   w_idx2_onehot;

    // Lowest set bit wins: bit 0 is the smallest tag.
    function automatic logic [N-1:0] pe(input logic [W-1:0] v);
        logic [N-1:0] idx;
        idx = '0;
        for (int i = W - 1; i >= 0; i--) begin
            if (v[i]) idx = N'(i);
        end
        return idx;
    endfunction

    assign w_ins_hit     = i_ins_valid && (i_ins_node_addr == r_idx1);
    assign w_scan_idx    = pe(i_l2_rd_data);
    assign w_scan_onehot = {{(W-1){1'b0}}, 1'b1} << w_scan_idx;
    assign w_data_zero   = (i_l2_rd_data == '0);
    assign w_node_last   = ((i_l2_rd_data & ~w_scan_onehot) == '0);
    assign w_idx2_onehot = {{(W-1){1'b0}}, 1'b1} << r_idx2;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_idx1     <= '0;
            r_idx2     <= '0;
            r_empty    <= 1'b0;
            r_err      <= 1'b0;
            r_root_clr <= 1'b0;
            r_hit      <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (ext.ext_req) begin
                        r_idx1     <= pe(i_root_bitmap);
                        r_idx2     <= '0;
                        r_empty    <= (i_root_bitmap == '0);
                        r_err      <= 1'b0;
                        r_root_clr <= 1'b0;
                        r_hit      <= 1'b0;
                    end
                end
                SCAN: begin
                    r_hit <= w_ins_hit;
                    if (w_data_zero) begin
                        r_err      <= 1'b1;
                        r_empty    <= 1'b1;
                        r_root_clr <= 1'b1;
                        r_idx2     <= '0;
                    end else begin
                        r_idx2     <= w_scan_idx;
                        r_root_clr <= w_node_last;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    always_comb begin
        w_state_nxt      = r_state;
        ext.ext_ready    = 1'b0;
        ext.tag_valid    = 1'b0;
        ext.tag_out      = '0;
        ext.tag_empty    = 1'b0;
        ext.err_incons   = 1'b0;
        o_root_clr_valid = 1'b0;
        o_root_clr_idx   = '0;
        o_l2_rd_en       = 1'b0;
        o_l2_rd_addr     = '0;
        o_l2_clr_valid   = 1'b0;
        o_l2_clr_addr    = '0;
        o_l2_clr_mask    = '0;

        case (r_state)
            IDLE: begin
                ext.ext_ready = 1'b1;
                if (ext.ext_req) begin
                    w_state_nxt = (i_root_bitmap == '0) ? DONE : READ;
                end
            end
            READ: begin
                o_l2_rd_en   = 1'b1;
                o_l2_rd_addr = r_idx1;
                w_state_nxt  = SCAN;
            end
            SCAN: begin
                w_state_nxt = CLEAR;
            end
            CLEAR: begin
                if (!r_err) begin
                    o_l2_clr_valid = 1'b1;
                    o_l2_clr_addr  = r_idx1;
                    o_l2_clr_mask  = w_idx2_onehot;
                end
                // An insert landing on this node keeps it non-empty, so its root bit must survive.
                if (r_root_clr && !r_hit && !w_ins_hit) begin
                    o_root_clr_valid = 1'b1;
                    o_root_clr_idx   = r_idx1;
                end
                w_state_nxt = DONE;
            end
            DONE: begin
                ext.tag_valid  = 1'b1;
                ext.tag_out    = r_empty ? '0 : {r_idx1, r_idx2};
                ext.tag_empty  = r_empty;
                ext.err_incons = r_err;
                w_state_nxt    = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

endmodule
